// File: rtl/sdram_pkg.sv
// Shared constants for the SDRAM refresh scheduler: FSM encoding, default
// timing and the pending-counter width helper.
package sdram_pkg;

  localparam logic [0:0] ST_DISABLED = 1'b0;
  localparam logic [0:0] ST_RUN      = 1'b1;

  localparam int REFRESH_PERIOD_DEFAULT = 780;
  localparam int MAX_PENDING_DEFAULT    = 8;

  // Smallest width that can hold the value max_pending itself.
  function automatic int pend_width(input int max_pending);
    return $clog2(max_pending + 1);
  endfunction

  localparam int PEND_W_DEFAULT = pend_width(MAX_PENDING_DEFAULT);

endpackage

// File: rtl/refresh_interval_cnt.sv
// Modulo-REFRESH_PERIOD interval counter with synchronous clear; tick marks
// the last count of each period while not cleared.
module refresh_interval_cnt #(
  parameter int SIZE           = 16,
  parameter int REFRESH_PERIOD = 780
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  output logic tick
);

  localparam logic [SIZE-1:0] LAST = SIZE'(REFRESH_PERIOD - 1);

  logic [SIZE-1:0] count;

  assign tick = !clear && (count == LAST);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                         count <= '0;
    else if (clear || count == LAST) count <= '0;
    else                             count <= count + SIZE'(1);
  end

endmodule

// File: rtl/sdram_refresh_sched.sv
// Refresh-credit scheduler: accrues one credit per interval, hands them to the
// sequencer over req/ack. Optional SDRAM_REFRESH_STATS_EN adds an issued count.
module sdram_refresh_sched
  import sdram_pkg::*;
#(
  parameter int SIZE           = 16,
  parameter int REFRESH_PERIOD = REFRESH_PERIOD_DEFAULT,
  parameter int MAX_PENDING    = MAX_PENDING_DEFAULT,
  parameter int URGENT_THRESH  = 6,
  parameter int PEND_W         = PEND_W_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              enable,
  input  logic              refresh_ack,
  output logic              refresh_req,
  output logic              refresh_urgent,
  output logic [PEND_W-1:0] pending_count,
  output logic              overflow
`ifdef SDRAM_REFRESH_STATS_EN
  ,
  output logic [15:0]       refresh_issued_cnt
`endif
);

  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);
  localparam logic [PEND_W-1:0] PEND_URG = PEND_W'(URGENT_THRESH);

  logic [0:0] state;
  logic       run_active;
  logic       tick;
  logic       ack_valid;

  // Dropping enable wins over any tick or ack in the same cycle.
  assign run_active = (state == ST_RUN) && enable;
  assign ack_valid  = run_active && refresh_ack && refresh_req;

  assign refresh_req    = (pending_count != '0);
  assign refresh_urgent = (pending_count >= PEND_URG);

  refresh_interval_cnt #(
    .SIZE           (SIZE),
    .REFRESH_PERIOD (REFRESH_PERIOD)
  ) u_interval (
    .CLK   (CLK),
    .RST   (RST),
    .clear (!run_active),
    .tick  (tick)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_DISABLED;
    else     state <= enable ? ST_RUN : ST_DISABLED;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pending_count <= '0;
      overflow      <= 1'b0;
    end else if (!run_active) begin
      pending_count <= '0;
    end else begin
      case ({tick, ack_valid})
        2'b10: begin
          if (pending_count == PEND_MAX) overflow      <= 1'b1;
          else                           pending_count <= pending_count + PEND_W'(1);
        end
        2'b01:   pending_count <= pending_count - PEND_W'(1);
        default: pending_count <= pending_count;
      endcase
    end
  end

`ifdef SDRAM_REFRESH_STATS_EN
  // Lifetime statistic: survives enable drops, cleared only by reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)            refresh_issued_cnt <= '0;
    else if (ack_valid) refresh_issued_cnt <= refresh_issued_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_sdram_refresh_sched.sv
// Directed bench for sdram_refresh_sched (REFRESH_PERIOD=10, MAX_PENDING=4,
// URGENT_THRESH=3); statistics checks compile in with SDRAM_REFRESH_STATS_EN.
module tb_sdram_refresh_sched;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       enable = 1'b0;
  logic       refresh_ack = 1'b0;
  logic       refresh_req;
  logic       refresh_urgent;
  logic [2:0] pending_count;
  logic       overflow;
`ifdef SDRAM_REFRESH_STATS_EN
  logic [15:0] refresh_issued_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  sdram_refresh_sched #(
    .SIZE           (8),
    .REFRESH_PERIOD (10),
    .MAX_PENDING    (4),
    .URGENT_THRESH  (3),
    .PEND_W         (3)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .enable         (enable),
    .refresh_ack    (refresh_ack),
    .refresh_req    (refresh_req),
    .refresh_urgent (refresh_urgent),
    .pending_count  (pending_count),
    .overflow       (overflow)
`ifdef SDRAM_REFRESH_STATS_EN
    ,
    .refresh_issued_cnt (refresh_issued_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int actual, input int expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Reset pulse; enable is already high, so RUN is entered at the first edge
  // after release and the first credit lands on edge 11 after release.
  task automatic restart();
    RST = 1'b1;
    #3;
    RST = 1'b0;
  endtask

  task automatic check_outputs(input string tag, input int pend, input int req,
                               input int urg, input int ovf);
    check({tag, ".pending"},  pending_count,  pend);
    check({tag, ".req"},      refresh_req,    req);
    check({tag, ".urgent"},   refresh_urgent, urg);
    check({tag, ".overflow"}, overflow,       ovf);
  endtask

  initial begin
    // Reset state.
    step(2);
    check_outputs("reset", 0, 0, 0, 0);
    RST = 1'b0;

    // Build pending=2, then async reset mid-cycle.
    enable = 1'b1;
    step(21);
    check_outputs("pre_rst", 2, 1, 0, 0);
    #2;
    RST = 1'b1;
    #1;
    check_outputs("async_rst", 0, 0, 0, 0);
    check("async_rst.count", dut.u_interval.count, 0);
    #1;
    RST = 1'b0;

    // Credits accrue on edges 11, 21, 31, 41; edge 51 overflows.
    step(10);
    check_outputs("e10", 0, 0, 0, 0);
    step(1);
    check_outputs("e11", 1, 1, 0, 0);
    step(10);
    check_outputs("e21", 2, 1, 0, 0);
    step(9);
    check_outputs("e30", 2, 1, 0, 0);
    step(1);
    check_outputs("e31", 3, 1, 1, 0);
    step(10);
    check_outputs("e41", 4, 1, 1, 0);
    step(10);
    check_outputs("e51_ovf", 4, 1, 1, 1);

    // Drain with acks on edges 52..55; overflow remains sticky.
    refresh_ack = 1'b1;
    step(1);
    check_outputs("drain1", 3, 1, 1, 1);
    step(3);
    refresh_ack = 1'b0;
    check_outputs("drained", 0, 0, 0, 1);
    refresh_ack = 1'b1;
    step(1);
    refresh_ack = 1'b0;
    check_outputs("ack_idle", 0, 0, 0, 1);

    // Fresh run: tick and ack together at pending=1 on edge 21.
    restart();
    step(11);
    check_outputs("r2_e11", 1, 1, 0, 0);
    step(9);
    refresh_ack = 1'b1;
    step(1);
    check_outputs("tick_ack", 1, 1, 0, 0);
    step(1);
    check_outputs("ack_to0", 0, 0, 0, 0);
    step(1);
    refresh_ack = 1'b0;
    check_outputs("ack_ignored", 0, 0, 0, 0);

    // Pending=3 at edge 51, then drop enable together with an ack.
    step(28);
    check_outputs("r2_e51", 3, 1, 1, 0);
    enable = 1'b0;
    refresh_ack = 1'b1;
    step(1);
    check_outputs("disable", 0, 0, 0, 0);
    check("disable.count", dut.u_interval.count, 0);
    enable = 1'b1;
    refresh_ack = 1'b0;
    step(10);
    check_outputs("reen_e62", 0, 0, 0, 0);
    step(1);
    check_outputs("reen_e63", 1, 1, 0, 0);

`ifdef SDRAM_REFRESH_STATS_EN
    // Valid acks so far since restart: edges 21 and 22.
    check("stats.pre", refresh_issued_cnt, 2);
    step(30);
    check_outputs("stats_fill", 4, 1, 1, 0);
    refresh_ack = 1'b1;
    step(6);
    refresh_ack = 1'b0;
    check_outputs("stats_drain", 0, 0, 0, 0);
    check("stats.count", refresh_issued_cnt, 6);
    step(4);
    check("stats.credit", pending_count, 1);
    force dut.refresh_issued_cnt = 16'hFFFF;
    #1;
    release dut.refresh_issued_cnt;
    refresh_ack = 1'b1;
    step(1);
    refresh_ack = 1'b0;
    check("stats.wrap", refresh_issued_cnt, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
